clk_div_multi: RTL and testbench
================================

// Module: clk_div_multi
// PURPOSE
//  Multi-channel programmable clock-enable/divider generator, driven from the board
//  system clock. Each channel produces a registered divided clock clk_out[i] of
//  period N_i cycles plus a one-cycle tick[i] strobe per period, for slow logic
//  (display scan, debounce, step clock) in the multi-cycle CPU top level.
//  Divisors are runtime-programmable and change glitch-free at period boundaries.
// PARAMETERS
//  NCH     4   number of independent divider channels (1..16)
//  DIV_W   16  divisor width in bits (2..32)
//  DEF_DIV 2   divisor loaded into every channel at reset (>=2, < 2**DIV_W)
// PORTS
//  clk       in   1          system clock; all logic on posedge clk
//  rst       in   1          asynchronous, active-high reset
//  en        in   NCH        per-channel run enable
//  div_val   in   NCH*DIV_W  divisor for channel i at [i*DIV_W +: DIV_W]
//  div_load  in   NCH        1-cycle strobe: capture div_val slice into shadow reg
//  sync_req  in   1          (only with CLKDIV_SYNC_EN) phase-align pulse
//  clk_out   out  NCH        divided clocks, registered
//  tick      out  NCH        1-cycle strobe coincident with each clk_out rising edge
//  running   out  NCH        channel is currently generating periods
// BEHAVIOUR
//  - Reset: cnt=0, active_div=shadow_div=DEF_DIV, clk_out=0, tick=0, running=0.
//  - Per channel: counter cnt in 0..N-1, N = active_div. Effective N<2 (0 or 1)
//    is clamped to 2; arithmetic is unsigned DIV_W bits; cnt never exceeds N-1.
//  - clk_out high while cnt < ceil(N/2), low otherwise -> period N, duty
//    ceil(N/2)/N (exact 50% for even N).
//  - Start: en sampled 1 with running=0 at edge t -> at t+1 running=1, cnt=0,
//    clk_out=1, tick=1. Latency en->first rising edge: 1 cycle.
//  - tick=1 exactly on cycles where cnt==0 and running=1; otherwise 0.
//  - Wrap: at cnt==N-1 next cnt=0; if shadow_div!=active_div, active_div<=shadow_div
//    on that same edge (new N used from the new period; no runt pulses ever).
//  - div_load[i]=1: shadow_div<=div_val slice next edge; repeated loads within one
//    period: last wins. Load while stopped: also copied to active_div immediately.
//  - Load on the same edge as wrap: wrap uses the OLD shadow; new value applies
//    at the following wrap.
//  - Stop: en=0 while running -> current period completes; at the wrap edge
//    running<=0, cnt<=0, clk_out<=0. en reasserted before the wrap cancels stop.
//  - Channels fully independent; no cross-channel phase relation unless synced.
//  - rst mid-operation: all channels return to reset state asynchronously;
//    clk_out drops immediately (async clear), shadow divisors lost.
// CONFIGURATION
//  CLKDIV_SYNC_EN defined: port sync_req present. sync_req=1 at edge t -> every
//    running channel has cnt=0, clk_out=1, tick=1 at t+1 (pending shadow divisors
//    applied on that edge); stopped channels unaffected; sync beats stop-at-wrap
//    (channel with en=0 stops at that edge instead).
//  CLKDIV_SYNC_EN undefined: no sync_req port; phases set only by start times.
// TESTING
//  1 rst, en[0]=1, DEF_DIV=2 -> clk_out[0] toggles 1,0,1,0; tick every 2nd cycle.
//  2 div_load[1] div=5, en[1]=1 -> clk_out[1] 1,1,1,0,0 repeating; tick period 5.
//  3 ch0 div=4 running, load div=7 mid-period -> current 4-cycle period completes,
//    then period 7 (high 4), no pulse shorter than 2 cycles.
//  4 div=0 and div=1 loaded -> behaves as div=2; en=0 mid-high -> finishes period,
//    clk_out=0, running=0, tick stays 0.
//  5 rst asserted mid-period with div=6 -> clk_out,tick,running=0 same cycle;
//    after release and en=1, period = DEF_DIV.
//  6 CLKDIV_SYNC_EN: ch0 div=3, ch1 div=8 offset; sync_req pulse -> next cycle
//    both tick=1, clk_out=11; subsequent ticks coincide every 24 cycles.

Source files
------------

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider with per-channel tick strobes and glitch-free divisor updates.
// Optional feature macro: CLKDIV_SYNC_EN adds the sync_req phase-alignment input.
module clk_div_multi #(
    parameter int NCH     = 4,
    parameter int DIV_W   = 16,
    parameter int DEF_DIV = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NCH-1:0]         en,
    input  logic [NCH*DIV_W-1:0]   div_val,
    input  logic [NCH-1:0]         div_load,
`ifdef CLKDIV_SYNC_EN
    input  logic                   sync_req,
`endif
    output logic [NCH-1:0]         clk_out,
    output logic [NCH-1:0]         tick,
    output logic [NCH-1:0]         running
);

    localparam logic [DIV_W-1:0] DEF_DIV_C = DIV_W'(DEF_DIV);

    // Divisors below 2 cannot form a high and a low phase, so they run as 2.
    function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] d);
        logic [DIV_W-1:0] r;
        if (d < DIV_W'(2)) begin
            r = DIV_W'(2);
        end else begin
            r = d;
        end
        return r;
    endfunction

    logic [DIV_W-1:0] cnt_q    [NCH];
    logic [DIV_W-1:0] cnt_d    [NCH];
    logic [DIV_W-1:0] active_q [NCH];
    logic [DIV_W-1:0] active_d [NCH];
    logic [DIV_W-1:0] shadow_q [NCH];
    logic [DIV_W-1:0] shadow_d [NCH];
    logic [NCH-1:0]   clk_out_q;
    logic [NCH-1:0]   clk_out_d;
    logic [NCH-1:0]   tick_q;
    logic [NCH-1:0]   tick_d;
    logic [NCH-1:0]   running_q;
    logic [NCH-1:0]   running_d;
    logic             sync_s;

`ifdef CLKDIV_SYNC_EN
    assign sync_s = sync_req;
`else
    assign sync_s = 1'b0;
`endif

    // Per-channel next-state: start, count, wrap (with divisor swap), stop and sync.
    always_comb begin : next_state_c
        logic [DIV_W-1:0] n_s;
        logic [DIV_W-1:0] half_s;
        logic [DIV_W-1:0] inc_s;
        logic [DIV_W-1:0] slice_s;
        logic             wrap_s;
        n_s       = DIV_W'(2);
        half_s    = DIV_W'(1);
        inc_s     = DIV_W'(0);
        slice_s   = DIV_W'(0);
        wrap_s    = 1'b0;
        clk_out_d = clk_out_q;
        tick_d    = {NCH{1'b0}};
        running_d = running_q;
        for (int i = 0; i < NCH; i++) begin
            slice_s     = div_val[i*DIV_W +: DIV_W];
            n_s         = eff_div(active_q[i]);
            half_s      = (n_s >> 1) + DIV_W'(n_s[0]);
            inc_s       = cnt_q[i] + DIV_W'(1);
            wrap_s      = (cnt_q[i] == (n_s - DIV_W'(1))) || sync_s;
            cnt_d[i]    = cnt_q[i];
            active_d[i] = active_q[i];

            if (div_load[i]) begin
                shadow_d[i] = slice_s;
            end else begin
                shadow_d[i] = shadow_q[i];
            end

            if (!running_q[i]) begin
                // Idle channel: loads take effect at once so the first period uses them.
                if (div_load[i]) begin
                    active_d[i] = slice_s;
                end else begin
                    active_d[i] = active_q[i];
                end
                cnt_d[i] = DIV_W'(0);
                if (en[i]) begin
                    running_d[i] = 1'b1;
                    clk_out_d[i] = 1'b1;
                    tick_d[i]    = 1'b1;
                end else begin
                    running_d[i] = 1'b0;
                    clk_out_d[i] = 1'b0;
                    tick_d[i]    = 1'b0;
                end
            end else if (wrap_s) begin
                // Period boundary: the divisor pending before this edge takes over.
                active_d[i] = shadow_q[i];
                cnt_d[i]    = DIV_W'(0);
                if (en[i]) begin
                    running_d[i] = 1'b1;
                    clk_out_d[i] = 1'b1;
                    tick_d[i]    = 1'b1;
                end else begin
                    running_d[i] = 1'b0;
                    clk_out_d[i] = 1'b0;
                    tick_d[i]    = 1'b0;
                end
            end else begin
                cnt_d[i]     = inc_s;
                running_d[i] = 1'b1;
                clk_out_d[i] = (inc_s < half_s);
                tick_d[i]    = 1'b0;
            end
        end
    end

    // State and output registers with asynchronous clear to the reset divisor.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i]    <= DIV_W'(0);
                active_q[i] <= DEF_DIV_C;
                shadow_q[i] <= DEF_DIV_C;
            end
            clk_out_q <= {NCH{1'b0}};
            tick_q    <= {NCH{1'b0}};
            running_q <= {NCH{1'b0}};
        end else begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i]    <= cnt_d[i];
                active_q[i] <= active_d[i];
                shadow_q[i] <= shadow_d[i];
            end
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
            running_q <= running_d;
        end
    end

    assign clk_out = clk_out_q;
    assign tick    = tick_q;
    assign running = running_q;

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi: a waveform-queue model checked every cycle plus literal checks.
module tb_clk_div_multi;

    localparam int NCH     = 4;
    localparam int DIV_W   = 16;
    localparam int DEF_DIV = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NCH-1:0]       en;
    logic [NCH*DIV_W-1:0] div_val;
    logic [NCH-1:0]       div_load;
    logic                 sync_req;
    logic [NCH-1:0]       clk_out;
    logic [NCH-1:0]       tick;
    logic [NCH-1:0]       running;

    always #5 clk = ~clk;

    clk_div_multi #(.NCH(NCH), .DIV_W(DIV_W), .DEF_DIV(DEF_DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .div_val  (div_val),
        .div_load (div_load),
`ifdef CLKDIV_SYNC_EN
        .sync_req (sync_req),
`endif
        .clk_out  (clk_out),
        .tick     (tick),
        .running  (running)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: each period is a queued waveform ----------------
    logic [1:0]       wq [NCH][$];
    logic [NCH-1:0]   m_run, m_clk, m_tick;
    logic [DIV_W-1:0] m_shadow [NCH];
    logic [DIV_W-1:0] m_old;
    logic [1:0]       m_e;
    logic             sync_m;

`ifdef CLKDIV_SYNC_EN
    assign sync_m = sync_req;
`else
    assign sync_m = 1'b0;
`endif

    function automatic int clampn(input logic [DIV_W-1:0] d);
        return (d < DIV_W'(2)) ? 2 : int'(d);
    endfunction

    task automatic fill(input int ch, input int n);
        for (int k = 0; k < n; k++) begin
            wq[ch].push_back({(k < (n + 1) / 2) ? 1'b1 : 1'b0, (k == 0) ? 1'b1 : 1'b0});
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                wq[i].delete();
                m_shadow[i] = DIV_W'(DEF_DIV);
            end
            m_run  = '0;
            m_clk  = '0;
            m_tick = '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                m_old = m_shadow[i];
                if (div_load[i]) m_shadow[i] = div_val[i*DIV_W +: DIV_W];
                if (!m_run[i]) begin
                    if (en[i]) begin
                        fill(i, clampn(m_shadow[i]));
                        m_run[i] = 1'b1;
                    end
                end else if (wq[i].size() == 0 || sync_m) begin
                    wq[i].delete();
                    if (en[i]) fill(i, clampn(m_old));
                    else m_run[i] = 1'b0;
                end
                if (m_run[i]) begin
                    m_e       = wq[i].pop_front();
                    m_clk[i]  = m_e[1];
                    m_tick[i] = m_e[0];
                end else begin
                    m_clk[i]  = 1'b0;
                    m_tick[i] = 1'b0;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (chk_on) begin
            chk("model_clk_out", 32'(clk_out), 32'(m_clk));
            chk("model_tick",    32'(tick),    32'(m_tick));
            chk("model_running", 32'(running), 32'(m_run));
        end
    end

    // ---------------- directed stimulus helpers ----------------
    task automatic cycles(input int n);
        for (int k = 0; k < n; k++) @(posedge clk);
        #2;
    endtask

    task automatic wait_tick(input int ch);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(posedge clk); #2;
            if (tick[ch]) seen = 1'b1;
        end
        if (!seen) chk("tick_timeout", 32'(0), 32'(1));
    endtask

    task automatic measure(input int ch, output int len, output int hi);
        bit done;
        done = 1'b0;
        len  = 1;
        hi   = int'(clk_out[ch]);
        for (int k = 0; k < 40 && !done; k++) begin
            @(posedge clk); #2;
            if (tick[ch]) done = 1'b1;
            else begin
                len++;
                hi += int'(clk_out[ch]);
            end
        end
        if (!done) chk("period_timeout", 32'(0), 32'(1));
    endtask

    task automatic load(input int ch, input logic [DIV_W-1:0] v);
        @(negedge clk);
        div_val[ch*DIV_W +: DIV_W] = v;
        div_load[ch] = 1'b1;
        @(negedge clk);
        div_load[ch] = 1'b0;
    endtask

    initial begin
        int len, hi, n;
        logic [3:0] p1;
        logic [4:0] p2;
        p1 = 4'b0101;
        p2 = 5'b00111;
        rst = 1'b1; en = '0; div_val = '0; div_load = '0; sync_req = 1'b0;
        cycles(3);
        @(negedge clk);
        rst = 1'b0;
        chk_on = 1'b1;
        chk("reset_clk_out", 32'(clk_out), 32'(0));
        chk("reset_running", 32'(running), 32'(0));

        // 1: default divisor 2 on ch0
        @(negedge clk); en[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #2;
            chk("t1_clk0",  32'(clk_out[0]), 32'(p1[k]));
            chk("t1_tick0", 32'(tick[0]),    32'(p1[k]));
        end

        // 2: divisor 5 on ch1
        @(negedge clk);
        div_val[1*DIV_W +: DIV_W] = 16'd5; div_load[1] = 1'b1;
        @(negedge clk);
        div_load[1] = 1'b0; en[1] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #2;
            chk("t2_clk1",  32'(clk_out[1]), 32'(p2[k % 5]));
            chk("t2_tick1", 32'(tick[1]),    32'((k % 5) == 0));
        end

        // 3: 4 -> 7 change requested mid-period
        load(0, 16'd4);
        cycles(6);
        wait_tick(0);
        @(negedge clk); div_val[0 +: DIV_W] = 16'd7; div_load[0] = 1'b1;
        @(negedge clk); div_load[0] = 1'b0;
        wait_tick(0);
        measure(0, len, hi);
        chk("t3_len7", 32'(len), 32'(7));
        chk("t3_hi7",  32'(hi),  32'(4));

        // 4: divisors 0 and 1 clamp to 2, then stop mid-high with divisor 6
        @(negedge clk);
        div_val[2*DIV_W +: DIV_W] = 16'd0; div_load[2] = 1'b1; en[2] = 1'b1;
        @(negedge clk); div_load[2] = 1'b0;
        wait_tick(2);
        measure(2, len, hi);
        chk("t4_len_div0", 32'(len), 32'(2));
        chk("t4_hi_div0",  32'(hi),  32'(1));
        load(2, 16'd1);
        cycles(4);
        wait_tick(2);
        measure(2, len, hi);
        chk("t4_len_div1", 32'(len), 32'(2));
        load(2, 16'd6);
        cycles(8);
        wait_tick(2);
        @(negedge clk); en[2] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #2;
            chk("t4_still_running", 32'(running[2]), 32'(1));
        end
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #2;
            chk("t4_stopped", 32'({running[2], clk_out[2], tick[2]}), 32'(0));
        end

        // stop cancelled by re-enable on ch3 (model-checked)
        @(negedge clk);
        div_val[3*DIV_W +: DIV_W] = 16'd3; div_load[3] = 1'b1; en[3] = 1'b1;
        @(negedge clk); div_load[3] = 1'b0;
        cycles(4);
        @(negedge clk); en[3] = 1'b0;
        @(negedge clk); en[3] = 1'b1;
        cycles(6);

        // 5: asynchronous reset mid-period with divisor 6
        load(0, 16'd6);
        cycles(10);
        wait_tick(0);
        cycles(2);
        chk("t5_running_before", 32'(running[0]), 32'(1));
        @(negedge clk);
        rst = 1'b1; en = '0;
        #1;
        chk("t5_async_clear", 32'({clk_out, tick, running}), 32'(0));
        cycles(2);
        @(negedge clk); rst = 1'b0;
        @(negedge clk); en[0] = 1'b1;
        wait_tick(0);
        measure(0, len, hi);
        chk("t5_len_def", 32'(len), 32'(DEF_DIV));
        chk("t5_hi_def",  32'(hi),  32'(1));

`ifdef CLKDIV_SYNC_EN
        // 6: phase alignment of 3 and 8 dividers
        @(negedge clk); en = '0;
        cycles(4);
        load(0, 16'd3);
        load(1, 16'd8);
        @(negedge clk); en[0] = 1'b1;
        cycles(2);
        @(negedge clk); en[1] = 1'b1;
        cycles(5);
        @(negedge clk); sync_req = 1'b1;
        @(posedge clk); #2;
        chk("t6_sync_tick", 32'(tick[1:0]),    32'(3));
        chk("t6_sync_clk",  32'(clk_out[1:0]), 32'(3));
        @(negedge clk); sync_req = 1'b0;
        n = 1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #2;
            if (tick[0] && tick[1]) break;
            n++;
        end
        chk("t6_coincide", 32'(n), 32'(24));
`endif

        cycles(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
